alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  Parametrised, registered ALU with a valid/ready handshake on input and output.
//  Supersedes the combinational ALU: WIDTH-generic, with signed/unsigned flags, shifts and nor.
//  Optionally adds an iterative multi-cycle multiply.
//  Sits between the decode/ALU-control stage and writeback in the datapath.
// PARAMETERS
//  WIDTH  32  operand/result width (>=4)
//  SHW    $clog2(WIDTH)  shift-amount width (localparam, derived)
// PORTS
//  clk       in   1      clock, rising edge
//  rst       in   1      asynchronous, active-high reset
//  in_valid  in   1      operation presented
//  in_ready  out  1      block can accept an operation this cycle
//  a, b      in   WIDTH  operands
//  mode      in   1      1 = signed, 0 = unsigned
//  opcode    in   4      operation code (table below)
//  shamt     in   SHW    shift amount
//  out_valid out  1      result/flags valid
//  out_ready in   1      consumer takes result this cycle
//  result    out  WIDTH  registered result
//  zero      out  1      result == 0
//  overflow  out  1      arithmetic overflow/carry/borrow per rules below
//  busy      out  1      multiply in progress
// BEHAVIOUR
//  Opcodes:
//   0000 and | 0001 or | 0010 add | 0110 sub | 0111 slt | 1100 nor
//   0100 sll | 0101 srl | 1000 sra | 1001 mul
//   Others: result 0, flags 0, single-cycle.
//  Reset: result=0, zero=0, overflow=0, out_valid=0, busy=0, FSM=IDLE.
//   in_ready=1 while rst is deasserted and out_valid=0.
//  Handshake: accept on in_valid && in_ready; drain on out_valid && out_ready.
//   in_ready = (state==IDLE) && (!out_valid || out_ready).
//   Outputs hold stable while out_valid && !out_ready.
//  Single-cycle ops: result/flags registered at the accept edge; out_valid=1 next cycle.
//   Full throughput (1 op/cycle) while out_ready=1.
//  add/sub, mode=1: overflow = signed two's-complement overflow.
//   add: a,b same sign, result sign differs from a.
//   sub: a,b signs differ, result sign differs from a.
//  add/sub, mode=0: overflow = carry-out (add) or borrow, a<b (sub).
//  slt: mode=1 signed compare, mode=0 unsigned; result 1 or 0; overflow=0.
//  Shifts:
//   sll/srl are logical; sra replicates a[WIDTH-1].
//   shamt only, mode ignored; overflow=0.
//  zero is computed from the registered result for every opcode, including unknown.
//  FSM: IDLE -> MUL (accepted mul) -> IDLE (after WIDTH iterations, result loaded).
//   out_valid pending when mul accepted is impossible (in_ready rule).
//  Reset mid-operation: immediate return to reset values; a partial product is discarded.
// CONFIGURATION
//  ALU_MUL_EN defined:
//   - mul is a shift-add loop, one bit per cycle, WIDTH cycles in state MUL.
//   - busy=1 and in_ready=0 during MUL; out_valid rises WIDTH+1 cycles after accept.
//   - Operands are converted to magnitude when mode=1; the 2*WIDTH product is
//     negated if the signs differ.
//   - result = low WIDTH bits.
//   - overflow = high half nonzero (mode=0), or product not representable as
//     signed WIDTH (mode=1).
//  ALU_MUL_EN undefined:
//   - 1001 decodes as unknown (result 0, flags 0, single cycle).
//   - MUL state and busy logic are absent; busy is tied to 0.
// TESTING (WIDTH=32)
//  1. add mode=1, 0x7FFFFFFF+0x1 -> result 0x80000000, overflow=1, out_valid 1 cycle after accept.
//  2. sub mode=0, 3-5 -> 0xFFFFFFFE, overflow=1.
//     slt 0xFFFFFFFF vs 0x1: mode=1 -> 1, mode=0 -> 0.
//  3. out_ready=0 with result pending: in_ready=0 and outputs frozen 5 cycles.
//     Raising out_ready drains and accepts the next op in the same cycle.
//  4. sra 0x80000000 shamt=4 -> 0xF8000000; srl -> 0x08000000; nor 0,0 -> 0xFFFFFFFF.
//  5. ALU_MUL_EN, mode=1, -3*7 -> 0xFFFFFFEB, overflow=0, out_valid 33 cycles after accept.
//     mode=0, 0x10000*0x10000 -> 0, overflow=1, zero=1.
//  6. rst pulsed at cycle 10 of a mul: out_valid=0, busy=0 immediately.
//     in_ready=1 after release; the next add completes normally.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe - registered ALU with valid/ready handshakes on both sides.
//
// Single-cycle ops (and/or/add/sub/slt/nor/sll/srl/sra) are computed
// combinationally from the inputs and captured at the accept edge, so
// out_valid_o rises one cycle after accept. Up to one op per cycle is
// accepted while the consumer keeps out_ready_o high.
//
// Optional feature macro: ALU_MUL_EN
//   defined   : opcode 1001 runs a shift-add multiply, one bit per cycle,
//               WIDTH cycles in state MUL (busy_o=1, in_ready_o=0).
//   undefined : 1001 is an unknown opcode (result 0, flags 0), busy_o=0.
//
// Ports
//   clk, rst           clock (rising edge), async active-high reset
//   in_valid_i/in_ready_o   operation handshake
//   a_i, b_i           operands (WIDTH)
//   mode_i             1 = signed, 0 = unsigned
//   opcode_i           4-bit operation code
//   shamt_i            shift amount (SHW = $clog2(WIDTH))
//   out_valid_o/out_ready_i result handshake
//   result_o, zero_o, overflow_o  registered result and flags
//   busy_o             multiply in progress
module alu_pipe #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             mode_i,
    input  logic [3:0]       opcode_i,
    input  logic [SHW-1:0]   shamt_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             overflow_o,
    output logic             busy_o
);
    localparam logic [3:0] OP_AND = 4'b0000, OP_OR  = 4'b0001, OP_ADD = 4'b0010,
                           OP_SUB = 4'b0110, OP_SLT = 4'b0111, OP_NOR = 4'b1100,
                           OP_SLL = 4'b0100, OP_SRL = 4'b0101, OP_SRA = 4'b1000,
                           OP_MUL = 4'b1001;

    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d, overflow_q, overflow_d;
    logic             out_valid_q, out_valid_d;
    logic             accept, accept_mul;
    logic [WIDTH-1:0] res_c;
    logic             ovf_c;
    logic [WIDTH:0]   sum_c, diff_c;

    // Extra top bit carries the unsigned carry-out / borrow.
    assign sum_c  = {1'b0, a_i} + {1'b0, b_i};
    assign diff_c = {1'b0, a_i} - {1'b0, b_i};

    always_comb begin
        res_c = '0;
        ovf_c = 1'b0;
        case (opcode_i)
            OP_AND: res_c = a_i & b_i;
            OP_OR:  res_c = a_i | b_i;
            OP_NOR: res_c = ~(a_i | b_i);
            OP_ADD: begin
                res_c = sum_c[WIDTH-1:0];
                ovf_c = mode_i ? ((a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum_c[WIDTH-1] != a_i[WIDTH-1]))
                               : sum_c[WIDTH];
            end
            OP_SUB: begin
                res_c = diff_c[WIDTH-1:0];
                ovf_c = mode_i ? ((a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff_c[WIDTH-1] != a_i[WIDTH-1]))
                               : diff_c[WIDTH];
            end
            OP_SLT: res_c = WIDTH'(mode_i ? ($signed(a_i) < $signed(b_i)) : (a_i < b_i));
            OP_SLL: res_c = a_i << shamt_i;
            OP_SRL: res_c = a_i >> shamt_i;
            OP_SRA: res_c = $unsigned($signed(a_i) >>> shamt_i);
            default: ;
        endcase
    end

`ifdef ALU_MUL_EN
    typedef enum logic {S_IDLE, S_MUL} state_t;
    state_t state_q, state_d;

    logic [2*WIDTH-1:0] mcand_q, acc_q, acc_nx, prod;
    logic [WIDTH-1:0]   mplier_q, mag_a, mag_b;
    logic [SHW-1:0]     cnt_q;
    logic               neg_q, sgn_q, mul_last, mul_ovf;

    assign accept_mul = accept && (opcode_i == OP_MUL);
    assign in_ready_o = (state_q == S_IDLE) && (!out_valid_q || out_ready_i);
    assign busy_o     = (state_q == S_MUL);

    assign mag_a    = (mode_i && a_i[WIDTH-1]) ? -a_i : a_i;
    assign mag_b    = (mode_i && b_i[WIDTH-1]) ? -b_i : b_i;
    assign mul_last = (state_q == S_MUL) && (cnt_q == SHW'(WIDTH-1));
    // The final iteration's sum feeds the result directly so the product
    // lands on the same edge that leaves MUL.
    assign acc_nx   = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign prod     = neg_q ? -acc_nx : acc_nx;
    // Signed: representable only if the top WIDTH+1 bits are all equal.
    assign mul_ovf  = sgn_q ? !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]))
                            : (|prod[2*WIDTH-1:WIDTH]);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept_mul) state_d = S_MUL;
            S_MUL:   if (mul_last)   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            sgn_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept_mul) begin
                mcand_q  <= {{WIDTH{1'b0}}, mag_a};
                mplier_q <= mag_b;
                acc_q    <= '0;
                cnt_q    <= '0;
                neg_q    <= mode_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                sgn_q    <= mode_i;
            end else if (state_q == S_MUL) begin
                acc_q    <= acc_nx;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + SHW'(1);
            end
        end
    end
`else
    assign accept_mul = 1'b0;
    assign in_ready_o = !out_valid_q || out_ready_i;
    assign busy_o     = 1'b0;
`endif

    assign accept = in_valid_i && in_ready_o;

    always_comb begin
        result_d    = result_q;
        zero_d      = zero_q;
        overflow_d  = overflow_q;
        out_valid_d = out_valid_q;
        if (out_valid_q && out_ready_i) out_valid_d = 1'b0;
        if (accept && !accept_mul) begin
            result_d    = res_c;
            overflow_d  = ovf_c;
            zero_d      = (res_c == '0);
            out_valid_d = 1'b1;
        end
`ifdef ALU_MUL_EN
        if (mul_last) begin
            result_d    = prod[WIDTH-1:0];
            overflow_d  = mul_ovf;
            zero_d      = (prod[WIDTH-1:0] == '0);
            out_valid_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q    <= '0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign result_o    = result_q;
    assign zero_o      = zero_q;
    assign overflow_o  = overflow_q;
    assign out_valid_o = out_valid_q;
endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] a = '0, b = '0;
    logic        mode = 1'b0;
    logic [3:0]  opcode = '0;
    logic [4:0]  shamt = '0;
    logic        out_valid, out_ready = 1'b1;
    logic [31:0] result;
    logic        zero, overflow, busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        zero;
    } exp_t;
    exp_t sb[$];

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    alu_pipe #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .a_i(a), .b_i(b), .mode_i(mode), .opcode_i(opcode), .shamt_i(shamt),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .result_o(result), .zero_o(zero), .overflow_o(overflow), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference model built on 64-bit arithmetic, independent of bit tricks.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                   input logic m, input logic [4:0] sh);
        exp_t e;
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint ux = longint'({32'b0, x});
        longint uy = longint'({32'b0, y});
        longint t;
        logic [63:0] pu;
        e.res = '0;
        e.ovf = 1'b0;
        case (op)
            4'b0000: e.res = x & y;
            4'b0001: e.res = x | y;
            4'b1100: e.res = ~(x | y);
            4'b0010: begin
                e.res = x + y;
                t = m ? sx + sy : ux + uy;
                e.ovf = m ? (t > SMAX || t < SMIN) : (t > 64'sd4294967295);
            end
            4'b0110: begin
                e.res = x - y;
                t = sx - sy;
                e.ovf = m ? (t > SMAX || t < SMIN) : (ux < uy);
            end
            4'b0111: e.res = m ? 32'(sx < sy) : 32'(ux < uy);
            4'b0100: e.res = x << sh;
            4'b0101: e.res = x >> sh;
            4'b1000: begin
                t = sx >>> sh;
                e.res = t[31:0];
            end
`ifdef ALU_MUL_EN
            4'b1001: begin
                if (m) begin
                    t = sx * sy;
                    e.res = t[31:0];
                    e.ovf = (t > SMAX || t < SMIN);
                end else begin
                    pu = {32'b0, x} * {32'b0, y};
                    e.res = pu[31:0];
                    e.ovf = (pu[63:32] != 32'b0);
                end
            end
`endif
            default: ;
        endcase
        e.zero = (e.res == 32'b0);
        return e;
    endfunction

    // Scoreboard consumer: one entry retired per drain handshake.
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_empty observed=unexpected_output expected=none");
            end else begin
                e = sb.pop_front();
                chk("res", result, e.res);
                chk("ovf", 32'(overflow), 32'(e.ovf));
                chk("zero", 32'(zero), 32'(e.zero));
            end
        end
    end

    // Present an op at a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic m, input logic [4:0] sh, output int waited);
        opcode = op; a = x; b = y; mode = m; shamt = sh; in_valid = 1'b1;
        waited = 0;
        #1;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $error("FAIL accept_timeout observed=in_ready_low expected=accept");
        end else begin
            sb.push_back(model(op, x, y, m, sh));
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int w;
        int n;
        exp_t snap;

        idle(2);
        #1;
        chk("rst_result", result, 32'h0);
        chk("rst_zero", 32'(zero), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        @(negedge clk);

        // signed add overflow, one-cycle latency
        send(4'b0010, 32'h7FFFFFFF, 32'h1, 1'b1, 5'd0, w);
        chk("add_lat_valid", 32'(out_valid), 32'h1);
        chk("add_res", result, 32'h80000000);
        chk("add_ovf", 32'(overflow), 32'h1);

        // back-to-back ops at full throughput
        send(4'b0110, 32'd3, 32'd5, 1'b0, 5'd0, w);
        chk("sub_res", result, 32'hFFFFFFFE);
        chk("sub_borrow", 32'(overflow), 32'h1);
        send(4'b0111, 32'hFFFFFFFF, 32'h1, 1'b1, 5'd0, w);
        chk("thr_stall0", 32'(w), 32'h0);
        chk("slt_signed", result, 32'h1);
        send(4'b0111, 32'hFFFFFFFF, 32'h1, 1'b0, 5'd0, w);
        chk("thr_stall1", 32'(w), 32'h0);
        chk("slt_unsigned", result, 32'h0);
        send(4'b0010, 32'hFFFFFFFF, 32'h1, 1'b0, 5'd0, w);
        send(4'b0110, 32'h80000000, 32'h1, 1'b1, 5'd0, w);
        send(4'b0000, 32'hF0F0A5A5, 32'h0FF0FFFF, 1'b0, 5'd0, w);
        send(4'b0001, 32'h12340000, 32'h00005678, 1'b0, 5'd0, w);
        idle(2);

        // backpressure: outputs frozen, in_ready low, then drain+accept same edge
        out_ready = 1'b0;
        send(4'b0001, 32'hA5A50000, 32'h00005A5A, 1'b0, 5'd0, w);
        snap = model(4'b0001, 32'hA5A50000, 32'h00005A5A, 1'b0, 5'd0);
        opcode = 4'b0010; a = 32'd10; b = 32'd20; mode = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_in_ready", 32'(in_ready), 32'h0);
            chk("stall_valid", 32'(out_valid), 32'h1);
            chk("stall_result", result, snap.res);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("drain_in_ready", 32'(in_ready), 32'h1);
        sb.push_back(model(4'b0010, 32'd10, 32'd20, 1'b0, 5'd0));
        @(negedge clk);
        in_valid = 1'b0;
        chk("drain_next_res", result, 32'd30);

        // shifts, nor, unknown opcode
        send(4'b1000, 32'h80000000, 32'h0, 1'b0, 5'd4, w);
        chk("sra_res", result, 32'hF8000000);
        send(4'b0101, 32'h80000000, 32'h0, 1'b1, 5'd4, w);
        chk("srl_res", result, 32'h08000000);
        send(4'b1100, 32'h0, 32'h0, 1'b0, 5'd0, w);
        chk("nor_res", result, 32'hFFFFFFFF);
        send(4'b0100, 32'h00000001, 32'h0, 1'b0, 5'd31, w);
        chk("sll_res", result, 32'h80000000);
        send(4'b0011, 32'h12345678, 32'h1, 1'b1, 5'd3, w);
        chk("unk_res", result, 32'h0);
        chk("unk_zero", 32'(zero), 32'h1);
        idle(2);

`ifdef ALU_MUL_EN
        send(4'b1001, 32'hFFFFFFFD, 32'd7, 1'b1, 5'd0, w);
        chk("mul_busy", 32'(busy), 32'h1);
        chk("mul_in_ready", 32'(in_ready), 32'h0);
        n = 1;
        while (out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("mul_latency", 32'(n), 32'd33);
        chk("mul_res", result, 32'hFFFFFFEB);
        chk("mul_ovf", 32'(overflow), 32'h0);
        idle(1);
        send(4'b1001, 32'h10000, 32'h10000, 1'b0, 5'd0, w);
        n = 1;
        while (out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("mulu_res", result, 32'h0);
        chk("mulu_ovf", 32'(overflow), 32'h1);
        chk("mulu_zero", 32'(zero), 32'h1);
        idle(2);

        // reset in the middle of a multiply
        send(4'b1001, 32'd5, 32'd6, 1'b0, 5'd0, w);
        idle(9);
        rst = 1'b1;
        #1;
        chk("mrst_valid", 32'(out_valid), 32'h0);
        chk("mrst_busy", 32'(busy), 32'h0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mrst_in_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        send(4'b0010, 32'd100, 32'd23, 1'b1, 5'd0, w);
        chk("mrst_add", result, 32'd123);
`else
        send(4'b1001, 32'd5, 32'd6, 1'b0, 5'd0, w);
        chk("nomul_valid", 32'(out_valid), 32'h1);
        chk("nomul_res", result, 32'h0);
        chk("nomul_busy", 32'(busy), 32'h0);
`endif

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        idle(1);
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
